tblights_monitor: RTL and testbench
===================================

# tblights_monitor

Sequence decoder and checker for the Thunderbird taillight outputs. It observes the six lamp lines LA..LC and RA..RC produced by the TBlights controller and reports the current display mode and phase. It flags every lamp pattern and every pattern-to-pattern transition that the controller is never allowed to produce. It sits beside TBlights on the same clock and clear, and gives on-board or in-simulation self-checking of the lamp sequencer.

## Interface
- ERR_W, default 8: width of the saturating error counter.
- clk  in  1  rising-edge clock, shared with TBlights.
- clear  in  1  asynchronous, active-low reset; clear=0 resets all state immediately.
- LA, LB, LC  in  1 each  left lamps; LA is innermost.
- RA, RB, RC  in  1 each  right lamps; RA is innermost.
- mode  out  2  decoded mode: 00 idle, 01 left, 10 right, 11 hazard.
- phase  out  2  lamps lit in the current pattern: 0..3. Hazard reports 3.
- seq_done  out  1  one-cycle pulse when a complete sequence returns to idle.
- err  out  1  one-cycle pulse on an illegal pattern or illegal transition.
- err_count  out  ERR_W  number of err pulses, saturating at all-ones.

## Operation
- Legal patterns, written as {LC,LB,LA,RA,RB,RC}:
  - IDLE = 000000
  - L1 = 001000, L2 = 011000, L3 = 111000
  - R1 = 000100, R2 = 000110, R3 = 000111
  - LR3 = 111111
  - Any other value is ILL.
- Tracker states: IDLE, L1, L2, L3, R1, R2, R3, LR3, UNK.
- Legal transitions, using the classified pattern at each sampling edge:
  - IDLE -> IDLE, L1, R1, LR3
  - L1 -> L2 or LR3; L2 -> L3 or LR3; L3 -> IDLE
  - R1 -> R2 or LR3; R2 -> R3 or LR3; R3 -> IDLE
  - LR3 -> IDLE
  - UNK -> any legal pattern, with no error (resynchronisation).
- Illegal transition between two legal patterns:
  - err=1.
  - The tracker adopts the new pattern as its state, so one glitch costs one error.
- ILL pattern:
  - err=1.
  - Tracker goes to UNK.
  - Mode and phase hold their previous values.
  - Every further ILL sample errors again.
- seq_done=1 on L3->IDLE, R3->IDLE and LR3->IDLE when the transition is legal. It never pulses on an error cycle.
- err_count increments by 1 on every err pulse and holds at 2^ERR_W-1.
- mode/phase per state:
  - IDLE: 00/0
  - Ln: 01/n
  - Rn: 10/n
  - LR3: 11/3

## Timing
- The lamp lines are sampled on every rising clk edge. All outputs are registered.
- The result for the pattern sampled at edge n is visible after edge n, so latency is one cycle.
- Reset values while clear=0: tracker IDLE, mode 00, phase 0, seq_done 0, err 0, err_count 0.
- Reset mid-sequence: state returns to IDLE at once, asynchronously.
- The first sample after clear rises is checked against IDLE. If the controller was also cleared it shows 000000, and no error is raised.
- Deassertion of clear is expected to be synchronous to the clock.
- Simultaneous error and counter saturation: err still pulses and the count stays at all-ones.
- Hold rule: a pattern repeated on consecutive edges is legal only in IDLE. L1 followed by L1 is an error, because the controller advances every clock.

## Structure
- Package tblights_pkg holds:
  - the state enum (IDLE, L1..L3, R1..R3, LR3, UNK, plus ILL as a classifier result)
  - the mode codes
  - the eight 6-bit pattern constants
- TBlights reuses the same package.
- Sub-module tblights_classify: purely combinational, maps the 6 lamp bits to a pattern code. It is instantiated once.
- The top module contains the tracker FSM, the transition check, the output registers and the saturating counter.

## Test plan
- Reset then idle: clear=0 for 2 cycles, then 5 cycles of 000000 -> mode 00, phase 0, err 0, err_count 0.
- Left sequence: IDLE, L1, L2, L3, IDLE -> phase 1, 2, 3, then 0; mode 01 during L1..L3; seq_done pulses once, on the cycle the return to IDLE is reported; err never asserts.
- Hazard override: IDLE, R1, LR3, IDLE -> mode 10 then 11 then 00; seq_done pulses once; err 0.
- Illegal transition: IDLE, L2 -> err pulses once, err_count=1, mode 01, phase 2. Then L3, IDLE -> no further error and seq_done=1.
- Illegal pattern and resync: 101000, 101000, then IDLE -> err on both ILL cycles, err_count=2, mode/phase held; IDLE accepted with no error.
- Saturation and reset: ERR_W=2, 5 consecutive ILL samples -> err_count stays 3 after the third. Then clear=0 mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tblights_pkg.sv
// tblights_pkg: shared pattern codes, mode codes and transition rules for TBlights and its monitor.
package tblights_pkg;

    typedef enum logic [3:0] {IDLE, L1, L2, L3, R1, R2, R3, LR3, UNK, ILL} state_t;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    // Bit order {LC,LB,LA,RA,RB,RC}
    localparam logic [5:0] PAT_IDLE = 6'b000000;
    localparam logic [5:0] PAT_L1   = 6'b001000;
    localparam logic [5:0] PAT_L2   = 6'b011000;
    localparam logic [5:0] PAT_L3   = 6'b111000;
    localparam logic [5:0] PAT_R1   = 6'b000100;
    localparam logic [5:0] PAT_R2   = 6'b000110;
    localparam logic [5:0] PAT_R3   = 6'b000111;
    localparam logic [5:0] PAT_LR3  = 6'b111111;

    function automatic logic legal_step(input state_t cur, input state_t nxt);
        case (cur)
            IDLE:    return nxt inside {IDLE, L1, R1, LR3};
            L1:      return nxt inside {L2, LR3};
            L2:      return nxt inside {L3, LR3};
            R1:      return nxt inside {R2, LR3};
            R2:      return nxt inside {R3, LR3};
            L3, R3, LR3: return nxt == IDLE;
            UNK:     return nxt != ILL;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] mode_of(input state_t s);
        return (s inside {L1, L2, L3}) ? MODE_LEFT :
               (s inside {R1, R2, R3}) ? MODE_RIGHT :
               (s == LR3)              ? MODE_HAZARD : MODE_IDLE;
    endfunction

    function automatic logic [1:0] phase_of(input state_t s);
        return (s inside {L1, R1})      ? 2'd1 :
               (s inside {L2, R2})      ? 2'd2 :
               (s inside {L3, R3, LR3}) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/tblights_classify.sv
// tblights_classify: maps the six lamp lines to a pattern code, ILL for anything unrecognised.
module tblights_classify
    import tblights_pkg::*;
(
    input  logic [5:0] lamps,
    output state_t     pat
);

    always_comb begin
        pat = (lamps == PAT_IDLE) ? IDLE :
              (lamps == PAT_L1)   ? L1 :
              (lamps == PAT_L2)   ? L2 :
              (lamps == PAT_L3)   ? L3 :
              (lamps == PAT_R1)   ? R1 :
              (lamps == PAT_R2)   ? R2 :
              (lamps == PAT_R3)   ? R3 :
              (lamps == PAT_LR3)  ? LR3 : ILL;
    end

endmodule

// File: rtl/tblights_monitor.sv
// tblights_monitor: tracks Thunderbird lamp patterns, reports mode/phase and flags illegal patterns or steps.
module tblights_monitor
    import tblights_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             LA,
    input  logic             LB,
    input  logic             LC,
    input  logic             RA,
    input  logic             RB,
    input  logic             RC,
    output logic [1:0]       mode,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    state_t           pat, state_q, state_d;
    logic [1:0]       mode_q, mode_d, phase_q, phase_d;
    logic             seq_done_q, seq_done_d, err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    tblights_classify u_classify (
        .lamps ({LC, LB, LA, RA, RB, RC}),
        .pat   (pat)
    );

    // An illegal step between legal patterns still adopts the new pattern, so one glitch costs one error.
    always_comb begin
        err_d       = (pat == ILL) || !legal_step(state_q, pat);
        state_d     = (pat == ILL) ? UNK : pat;
        seq_done_d  = !err_d && (pat == IDLE) && (state_q inside {L3, R3, LR3});
        mode_d      = (pat == ILL) ? mode_q : mode_of(pat);
        phase_d     = (pat == ILL) ? phase_q : phase_of(pat);
        err_count_d = (err_d && err_count_q != '1) ? err_count_q + ERR_W'(1) : err_count_q;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            mode_q      <= MODE_IDLE;
            phase_q     <= 2'd0;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            seq_done_q  <= seq_done_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign mode      = mode_q;
    assign phase     = phase_q;
    assign seq_done  = seq_done_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_tblights_monitor.sv
// tb_tblights_monitor: directed and random lamp streams checked against a pattern/transition-table model.
module tb_tblights_monitor;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] lamps = 6'b0;
    logic [1:0] mode, phase, mode2, phase2;
    logic       seq_done, err, seq_done2, err2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tblights_monitor #(.ERR_W(8)) dut (
        .clk(clk), .clear(clear),
        .LA(lamps[3]), .LB(lamps[4]), .LC(lamps[5]),
        .RA(lamps[2]), .RB(lamps[1]), .RC(lamps[0]),
        .mode(mode), .phase(phase), .seq_done(seq_done), .err(err), .err_count(cnt)
    );

    tblights_monitor #(.ERR_W(2)) dut2 (
        .clk(clk), .clear(clear),
        .LA(lamps[3]), .LB(lamps[4]), .LC(lamps[5]),
        .RA(lamps[2]), .RB(lamps[1]), .RC(lamps[0]),
        .mode(mode2), .phase(phase2), .seq_done(seq_done2), .err(err2), .err_count(cnt2)
    );

    // Allowed {from,to} pattern pairs; every legal pattern appears as a destination.
    logic [11:0] pairs [15] = '{
        {6'b000000, 6'b000000}, {6'b000000, 6'b001000}, {6'b000000, 6'b000100}, {6'b000000, 6'b111111},
        {6'b001000, 6'b011000}, {6'b001000, 6'b111111}, {6'b011000, 6'b111000}, {6'b011000, 6'b111111},
        {6'b111000, 6'b000000},
        {6'b000100, 6'b000110}, {6'b000100, 6'b111111}, {6'b000110, 6'b000111}, {6'b000110, 6'b111111},
        {6'b000111, 6'b000000}, {6'b111111, 6'b000000}
    };

    logic [5:0] m_prev;
    bit         m_unk, m_seq, m_err;
    logic [1:0] m_mode, m_phase;
    int         m_cnt8, m_cnt2;

    function automatic bit is_legal(input logic [5:0] p);
        foreach (pairs[i]) if (pairs[i][5:0] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit allowed(input logic [5:0] a, input logic [5:0] b);
        foreach (pairs[i]) if (pairs[i] == {a, b}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_prev = 6'b0; m_unk = 0; m_seq = 0; m_err = 0;
        m_mode = 2'd0; m_phase = 2'd0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(input logic [5:0] p);
        int nl, nr;
        if (!is_legal(p)) begin
            m_err = 1; m_seq = 0; m_unk = 1;
        end else begin
            nl = $countones(p[5:3]);
            nr = $countones(p[2:0]);
            m_err = !(m_unk || allowed(m_prev, p));
            m_seq = !m_err && !m_unk && p == 6'b0 &&
                    (m_prev == 6'b111000 || m_prev == 6'b000111 || m_prev == 6'b111111);
            m_prev = p;
            m_unk = 0;
            m_mode = {nr != 0, nl != 0};
            m_phase = 2'((nl > nr) ? nl : nr);
        end
        if (m_err && m_cnt8 < 255) m_cnt8++;
        if (m_err && m_cnt2 < 3) m_cnt2++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mode"}, 32'(mode), 32'(m_mode));
        chk({tag, ".phase"}, 32'(phase), 32'(m_phase));
        chk({tag, ".seq_done"}, 32'(seq_done), 32'(m_seq));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".err_count"}, 32'(cnt), 32'(m_cnt8));
        chk({tag, ".err_count_w2"}, 32'(cnt2), 32'(m_cnt2));
        chk({tag, ".err_w2"}, 32'(err2), 32'(m_err));
    endtask

    task automatic step(input string tag, input logic [5:0] p);
        lamps = p;
        @(posedge clk);
        model_step(p);
        #1;
        check_all(tag);
    endtask

    function automatic logic [5:0] pick();
        logic [5:0] q[$];
        int r = int'($urandom_range(0, 19));
        if (r < 15 && !m_unk) begin
            foreach (pairs[i]) if (pairs[i][11:6] == m_prev) q.push_back(pairs[i][5:0]);
            return q[$urandom_range(0, q.size() - 1)];
        end
        if (r < 18) return pairs[$urandom_range(0, 14)][5:0];
        return 6'($urandom);
    endfunction

    initial begin
        model_reset();
        #1 check_all("reset_t0");
        repeat (2) @(posedge clk);
        #1 check_all("reset_held");
        @(negedge clk) clear = 1'b1;
        repeat (5) step("idle", 6'b000000);
        step("left1", 6'b001000);
        step("left2", 6'b011000);
        step("left3", 6'b111000);
        step("left_done", 6'b000000);
        step("haz_r1", 6'b000100);
        step("haz_lr3", 6'b111111);
        step("haz_done", 6'b000000);
        step("jump_l2", 6'b011000);
        step("jump_l3", 6'b111000);
        step("jump_done", 6'b000000);
        step("ill_a", 6'b101000);
        step("ill_b", 6'b101000);
        step("resync", 6'b000000);
        step("hold_l1", 6'b001000);
        step("hold_l1_again", 6'b001000);
        step("hold_l2", 6'b011000);
        step("hold_l3", 6'b111000);
        step("hold_done", 6'b000000);
        repeat (5) step("sat_ill", 6'b101010);
        step("mid_l1", 6'b001000);
        step("mid_l2", 6'b011000);
        #2 clear = 1'b0;
        #1 model_reset();
        check_all("async_clear");
        repeat (2) @(posedge clk);
        #1 check_all("clear_held");
        @(negedge clk) clear = 1'b1;
        step("after_clear", 6'b000000);
        for (int i = 0; i < 400; i++) step("rand", pick());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
